round_ctrl: RTL and testbench

ROUND_CTRL -- requirements
Module: round_ctrl

---
 rtl/round_ctrl.sv | 168 ++++++++++++++++
 tb/tb_round_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/round_ctrl.sv
// Round controller for a pose-matching reaction game: boss pose generation,
// response-window judgement, BCD score keeping and a BCD countdown timer.
module round_ctrl #(
    parameter int         GAME_SECONDS = 60,
    parameter int         WINDOW_MS    = 1000,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_ms,
    input  logic       start,
    input  logic       act,
    input  logic [1:0] player_state,
    output logic [1:0] boss_state,
    output logic [3:0] score_ones,
    output logic [3:0] score_tens,
    output logic [3:0] time_ones,
    output logic [3:0] time_tens,
    output logic       hit,
    output logic       miss,
    output logic       game_over,
    output logic [1:0] fsm_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_OVER = 2'd3;

    localparam logic [3:0] GAME_TENS   = 4'(GAME_SECONDS / 10);
    localparam logic [3:0] GAME_ONES   = 4'(GAME_SECONDS % 10);
    localparam logic [9:0] WINDOW_LOAD = 10'(WINDOW_MS);
    localparam logic [9:0] MS_LAST     = 10'd999;

    logic [1:0] state;
    logic [1:0] state_next;
    logic [7:0] lfsr;
    logic       lfsr_fb;
    logic [9:0] ms_cnt;
    logic [9:0] win_cnt;
    logic [1:0] pose_pick;

    logic running;
    logic begin_round;
    logic judge_act;
    logic act_hit;
    logic act_miss;
    logic win_expire;
    logic sec_tick;
    logic time_last;
    logic round_end;
    logic score_max;

    assign running     = (state == ST_ARM) || (state == ST_WAIT);
    assign begin_round = start && ((state == ST_IDLE) || (state == ST_OVER));

    // An act always takes precedence over a window expiry in the same cycle.
    assign judge_act  = (state == ST_WAIT) && act;
    assign act_hit    = judge_act && (player_state == boss_state);
    assign act_miss   = judge_act && (player_state != boss_state);
    assign win_expire = (state == ST_WAIT) && !act && tick_ms && (win_cnt == 10'd1);

    assign sec_tick  = running && tick_ms && (ms_cnt == MS_LAST);
    assign time_last = (time_tens == 4'd0) && (time_ones == 4'd1);
    assign round_end = sec_tick && time_last;
    assign score_max = (score_tens == 4'd9) && (score_ones == 4'd9);

    // New pose must differ from the current one, so bump by one on a repeat.
    assign pose_pick = (lfsr[1:0] == boss_state) ? (lfsr[1:0] + 2'd1) : lfsr[1:0];

    assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign game_over = (state == ST_OVER);
    assign fsm_state = state;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_OVER: if (start) state_next = ST_ARM;
            ST_ARM:           state_next = ST_WAIT;
            ST_WAIT:          if (judge_act || win_expire) state_next = ST_ARM;
            default:          state_next = ST_IDLE;
        endcase
        if (round_end) state_next = ST_OVER;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            lfsr  <= LFSR_SEED;
        end else begin
            state <= state_next;
            lfsr  <= {lfsr[6:0], lfsr_fb};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            boss_state <= 2'd0;
        end else if (state == ST_ARM) begin
            boss_state <= pose_pick;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt <= 10'd0;
        end else if (begin_round) begin
            win_cnt <= 10'd0;
        end else if (state == ST_ARM) begin
            win_cnt <= WINDOW_LOAD;
        end else if ((state == ST_WAIT) && !act && tick_ms) begin
            win_cnt <= win_cnt - 10'd1;
        end
    end

    // Millisecond prescaler and the seconds-remaining BCD countdown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_cnt    <= 10'd0;
            time_ones <= GAME_ONES;
            time_tens <= GAME_TENS;
        end else if (begin_round) begin
            ms_cnt    <= 10'd0;
            time_ones <= GAME_ONES;
            time_tens <= GAME_TENS;
        end else if (running && tick_ms) begin
            if (ms_cnt == MS_LAST) begin
                ms_cnt <= 10'd0;
                if (time_ones == 4'd0) begin
                    time_ones <= 4'd9;
                    time_tens <= time_tens - 4'd1;
                end else begin
                    time_ones <= time_ones - 4'd1;
                end
            end else begin
                ms_cnt <= ms_cnt + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_ones <= 4'd0;
            score_tens <= 4'd0;
        end else if (begin_round) begin
            score_ones <= 4'd0;
            score_tens <= 4'd0;
        end else if (act_hit && !score_max) begin
            if (score_ones == 4'd9) begin
                score_ones <= 4'd0;
                score_tens <= score_tens + 4'd1;
            end else begin
                score_ones <= score_ones + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit  <= 1'b0;
            miss <= 1'b0;
        end else begin
            hit  <= act_hit;
            miss <= act_miss || win_expire;
        end
    end

endmodule

// File: tb/tb_round_ctrl.sv
// Self-checking bench for round_ctrl: a cycle-level game model is compared
// against the DUT every cycle, plus hand-computed literal checkpoints.
module tb_round_ctrl;

    localparam int GS  = 3;
    localparam int WIN = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_ms = 1'b0;
    logic       start = 1'b0;
    logic       act = 1'b0;
    logic [1:0] player_state = 2'd0;
    logic [1:0] boss_state;
    logic [3:0] score_ones, score_tens, time_ones, time_tens;
    logic       hit, miss, game_over;
    logic [1:0] fsm_state;

    round_ctrl #(.GAME_SECONDS(GS), .WINDOW_MS(WIN), .LFSR_SEED(8'hA5)) dut (
        .clk(clk), .reset(reset), .tick_ms(tick_ms), .start(start), .act(act),
        .player_state(player_state), .boss_state(boss_state),
        .score_ones(score_ones), .score_tens(score_tens),
        .time_ones(time_ones), .time_tens(time_tens),
        .hit(hit), .miss(miss), .game_over(game_over), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model of the game in plain integers: phase 0..3, score, seconds, ms, window.
    int         m_phase = 0;
    int         m_score = 0;
    int         m_time  = GS;
    int         m_ms    = 0;
    int         m_win   = 0;
    logic [7:0] m_lfsr  = 8'hA5;
    logic [1:0] m_boss  = 2'd0;
    logic       m_hit   = 1'b0;
    logic       m_miss  = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & 8'hB8)};
    endfunction

    task automatic model_step();
        int         old_phase;
        logic [1:0] pick;
        m_hit  = 1'b0;
        m_miss = 1'b0;
        if (reset) begin
            m_phase = 0; m_lfsr = 8'hA5; m_boss = 2'd0; m_score = 0;
            m_time = GS; m_ms = 0; m_win = 0;
            return;
        end
        old_phase = m_phase;
        case (old_phase)
            0, 3: if (start) begin
                m_score = 0; m_time = GS; m_ms = 0; m_win = 0; m_phase = 1;
            end
            1: begin
                pick = m_lfsr[1:0];
                if (pick == m_boss) pick = pick + 2'd1;
                m_boss  = pick;
                m_win   = WIN;
                m_phase = 2;
            end
            2: if (act) begin
                if (player_state == m_boss) begin
                    m_hit = 1'b1;
                    if (m_score < 99) m_score++;
                end else begin
                    m_miss = 1'b1;
                end
                m_phase = 1;
            end else if (tick_ms) begin
                m_win--;
                if (m_win == 0) begin
                    m_miss  = 1'b1;
                    m_phase = 1;
                end
            end
            default: ;
        endcase
        if ((old_phase == 1 || old_phase == 2) && tick_ms) begin
            m_ms++;
            if (m_ms == 1000) begin
                m_ms = 0;
                m_time--;
                if (m_time == 0) m_phase = 3;
            end
        end
        m_lfsr = lfsr_step(m_lfsr);
    endtask

    task automatic check_output();
        check("fsm_state",  int'(fsm_state),  m_phase);
        check("boss_state", int'(boss_state), int'(m_boss));
        check("score_tens", int'(score_tens), m_score / 10);
        check("score_ones", int'(score_ones), m_score % 10);
        check("time_tens",  int'(time_tens),  m_time / 10);
        check("time_ones",  int'(time_ones),  m_time % 10);
        check("hit",        int'(hit),        int'(m_hit));
        check("miss",       int'(miss),       int'(m_miss));
        check("game_over",  int'(game_over),  int'(m_phase == 3));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            check_output();
        end
    end

    task automatic apply_stimulus(input logic s, input logic a, input logic [1:0] p, input logic t);
        start = s; act = a; player_state = p; tick_ms = t;
        @(negedge clk);
        start = 1'b0; act = 1'b0; tick_ms = 1'b0;
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check("rst_fsm",   int'(fsm_state), 0);
        check("rst_score", int'(score_tens) * 10 + int'(score_ones), 0);
        check("rst_time",  int'(time_tens) * 10 + int'(time_ones), 3);
        check("rst_boss",  int'(boss_state), 0);
        check("rst_pulse", int'(hit) + int'(miss) + int'(game_over), 0);
        check("rst_lfsr",  int'(dut.lfsr), 'hA5);

        // Release reset and start together: ARM sees lfsr 8'h4A, so pose 2.
        reset = 1'b0;
        apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0);
        check("start_arm", int'(fsm_state), 1);
        apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0);
        check("arm_wait",   int'(fsm_state), 2);
        check("first_pose", int'(boss_state), 2);
        check("start_time", int'(time_tens) * 10 + int'(time_ones), 3);

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(1'b0, 1'b1, m_boss, 1'b0);
            check("hit_pulse",  int'(hit), 1);
            check("hit_to_arm", int'(fsm_state), 1);
            apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0);
        end
        check("score_07", int'(score_tens) * 10 + int'(score_ones), 7);

        // Asynchronous reset in the middle of a round.
        reset = 1'b1;
        #1;
        check("midrst_fsm",   int'(fsm_state), 0);
        check("midrst_score", int'(score_tens) * 10 + int'(score_ones), 0);
        check("midrst_time",  int'(time_tens) * 10 + int'(time_ones), 3);
        check("midrst_boss",  int'(boss_state), 0);
        check("midrst_lfsr",  int'(dut.lfsr), 'hA5);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) apply_stimulus(1'b0, 1'b1, 2'd0, 1'b1);
        check("idle_hold", int'(fsm_state), 0);

        apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b0, 1'b1, m_boss, 1'b0);
            check("hit10_pulse", int'(hit), 1);
            apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0);
        end
        check("score_tens_10", int'(score_tens), 1);
        check("score_ones_10", int'(score_ones), 0);

        apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0);
        check("start_in_wait", int'(fsm_state), 2);

        // Window expiry after five ticks.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, 1'b0, 2'd0, 1'b1);
            check("win_no_miss", int'(miss), 0);
        end
        apply_stimulus(1'b0, 1'b0, 2'd0, 1'b1);
        check("win_miss",  int'(miss), 1);
        check("win_arm",   int'(fsm_state), 1);
        check("win_score", int'(score_tens) * 10 + int'(score_ones), 10);
        apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0);

        // Act coinciding with window expiry: the act decides.
        repeat (4) apply_stimulus(1'b0, 1'b0, 2'd0, 1'b1);
        apply_stimulus(1'b0, 1'b1, m_boss ^ 2'd1, 1'b1);
        check("wrong_exp_miss", int'(miss), 1);
        check("wrong_exp_hit",  int'(hit), 0);
        apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0);
        repeat (4) apply_stimulus(1'b0, 1'b0, 2'd0, 1'b1);
        apply_stimulus(1'b0, 1'b1, m_boss, 1'b1);
        check("right_exp_hit",  int'(hit), 1);
        check("right_exp_miss", int'(miss), 0);
        check("right_exp_score", int'(score_tens) * 10 + int'(score_ones), 11);

        n = 0;
        while (!game_over && n < 4000) begin
            apply_stimulus(1'b0, 1'b0, 2'd0, 1'b1);
            n++;
        end
        check("over1_reached", int'(game_over), 1);
        check("over1_time", int'(time_tens) * 10 + int'(time_ones), 0);
        repeat (3) apply_stimulus(1'b0, 1'b1, m_boss, 1'b1);
        check("over_hold_fsm",   int'(fsm_state), 3);
        check("over_hold_score", int'(score_tens) * 10 + int'(score_ones), 11);

        apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0);
        check("restart_fsm",   int'(fsm_state), 1);
        check("restart_score", int'(score_tens) * 10 + int'(score_ones), 0);
        check("restart_time",  int'(time_tens) * 10 + int'(time_ones), 3);
        check("restart_go",    int'(game_over), 0);

        // Full round: exactly 3000 ticks from here to OVER.
        apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0);
        n = 0;
        while (!game_over && n < 4000) begin
            apply_stimulus(1'b0, 1'b0, 2'd0, 1'b1);
            n++;
        end
        check("ticks_to_over", n, 3000);
        check("over2_fsm",  int'(fsm_state), 3);
        check("over2_time", int'(time_tens) * 10 + int'(time_ones), 0);
        repeat (2) apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
